// File: rtl/exm_pkg.sv
// Shared encodings for the ECAP5-DPROC execute stage: ALU functions, branch
// conditions, load-store widths and result selection.
package ecap5_dproc_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SLL  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SRL  = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;

    // Nine conditions do not fit in three bits, so JAL and JALR share one code:
    // decode feeds pc and the J-immediate into the ALU for JAL, making the ALU
    // sum the jump target for both.
    typedef enum logic [2:0] {
        BRANCH_NONE = 3'd0,
        BRANCH_EQ   = 3'd1,
        BRANCH_NE   = 3'd2,
        BRANCH_LT   = 3'd3,
        BRANCH_GE   = 3'd4,
        BRANCH_LTU  = 3'd5,
        BRANCH_GEU  = 3'd6,
        BRANCH_JALR = 3'd7
    } branch_cond_t;

    localparam branch_cond_t BRANCH_JAL = BRANCH_JALR;

    typedef enum logic [1:0] {
        LS_BYTE = 2'b00,
        LS_HALF = 2'b01,
        LS_WORD = 2'b10
    } ls_width_t;

    localparam logic RESULT_ALU = 1'b0;
    localparam logic RESULT_PC4 = 1'b1;

    // Byte-lane mask for an access at offset 0; the reserved width selects no lanes.
    function automatic logic [3:0] ls_base_sel(input logic [1:0] width);
        logic [3:0] sel;
        case (width)
            LS_BYTE: sel = 4'b0001;
            LS_HALF: sel = 4'b0011;
            LS_WORD: sel = 4'b1111;
            default: sel = 4'b0000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/exm_if.sv
// Result bundle from the execute stage to the load-store stage, with its
// valid/ready handshake.
interface exm_if;
    logic        output_valid;
    logic        output_ready;
    logic [31:0] alu_result;
    logic        enable;
    logic        write;
    logic [31:0] write_data;
    logic [3:0]  sel;
    logic        reg_write;
    logic [4:0]  reg_addr;
    logic        branch;
    logic [31:0] branch_target;

    modport master (
        output output_valid, alu_result, enable, write, write_data, sel,
               reg_write, reg_addr, branch, branch_target,
        input  output_ready
    );

    modport slave (
        input  output_valid, alu_result, enable, write, write_data, sel,
               reg_write, reg_addr, branch, branch_target,
        output output_ready
    );
endinterface

// File: rtl/exm_alu.sv
// Combinational integer ALU plus branch comparator for the execute stage.
// The plain operand sum is exported separately for addresses and JALR targets.
module exm_alu
    import ecap5_dproc_pkg::*;
(
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  logic [2:0]  op,
    input  logic        alt,
    input  logic [31:0] cmp_op1,
    input  logic [31:0] cmp_op2,
    input  logic [2:0]  cond,
    output logic [31:0] result,
    output logic [31:0] sum,
    output logic        taken
);
    logic [4:0] shamt;
    logic       cmp_eq;
    logic       cmp_lt;
    logic       cmp_ltu;

    assign shamt   = operand2[4:0];
    assign sum     = operand1 + operand2;
    assign cmp_eq  = (cmp_op1 == cmp_op2);
    assign cmp_lt  = ($signed(cmp_op1) < $signed(cmp_op2));
    assign cmp_ltu = (cmp_op1 < cmp_op2);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = alt ? (operand1 - operand2) : sum;
            ALU_SLL:  result = operand1 << shamt;
            ALU_SLT:  result = {31'b0, $signed(operand1) < $signed(operand2)};
            ALU_SLTU: result = {31'b0, operand1 < operand2};
            ALU_XOR:  result = operand1 ^ operand2;
            ALU_SRL:  result = alt ? $unsigned($signed(operand1) >>> shamt)
                                   : (operand1 >> shamt);
            ALU_OR:   result = operand1 | operand2;
            ALU_AND:  result = operand1 & operand2;
            default:  result = '0;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (cond)
            BRANCH_EQ:   taken = cmp_eq;
            BRANCH_NE:   taken = !cmp_eq;
            BRANCH_LT:   taken = cmp_lt;
            BRANCH_GE:   taken = !cmp_lt;
            BRANCH_LTU:  taken = cmp_ltu;
            BRANCH_GEU:  taken = !cmp_ltu;
            BRANCH_JALR: taken = 1'b1;
            default:     taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/exm.sv
// ECAP5-DPROC execute stage: ALU, branch resolution and load-store request
// building, registered into a single-entry output stage for load-store.
module exm
    import ecap5_dproc_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        input_valid_i,
    output logic        input_ready_o,
    input  logic [31:0] pc_i,
    input  logic [31:0] alu_operand1_i,
    input  logic [31:0] alu_operand2_i,
    input  logic [2:0]  alu_op_i,
    input  logic        alu_alt_i,
    input  logic        result_sel_i,
    input  logic [2:0]  branch_cond_i,
    input  logic [31:0] branch_offset_i,
    input  logic [31:0] branch_op1_i,
    input  logic [31:0] branch_op2_i,
    input  logic        ls_enable_i,
    input  logic        ls_write_i,
    input  logic [1:0]  ls_width_i,
    input  logic [31:0] ls_data_i,
    input  logic        reg_write_i,
    input  logic [4:0]  reg_addr_i,
    exm_if.master       ls
);
    logic [31:0] alu_result;
    logic [31:0] alu_sum;
    logic        branch_taken;

    exm_alu u_alu (
        .operand1 (alu_operand1_i),
        .operand2 (alu_operand2_i),
        .op       (alu_op_i),
        .alt      (alu_alt_i),
        .cmp_op1  (branch_op1_i),
        .cmp_op2  (branch_op2_i),
        .cond     (branch_cond_i),
        .result   (alu_result),
        .sum      (alu_sum),
        .taken    (branch_taken)
    );

    logic        valid_q;
    logic        branch_q;
    logic        enable_q;
    logic        write_q;
    logic        reg_write_q;
    logic [31:0] result_q;
    logic [31:0] wdata_q;
    logic [31:0] target_q;
    logic [3:0]  sel_q;
    logic [4:0]  reg_addr_q;

    logic        accept;
    logic [1:0]  byte_off;
    logic [3:0]  sel_d;
    logic [31:0] wdata_d;
    logic [31:0] result_d;
    logic [31:0] target_d;

    assign input_ready_o = !valid_q || ls.output_ready;
    assign accept        = input_valid_i && input_ready_o;

    // Misaligned accesses simply lose the lanes shifted past bit 3 / bit 31.
    always_comb begin
        byte_off    = alu_sum[1:0];
        sel_d       = ls_enable_i ? (ls_base_sel(ls_width_i) << byte_off) : 4'b0000;
        wdata_d     = ls_data_i << {byte_off, 3'b000};
        result_d    = (result_sel_i == RESULT_PC4) ? (pc_i + 32'd4) : alu_result;
        target_d    = (branch_cond_i == BRANCH_JALR) ? alu_sum : (pc_i + branch_offset_i);
        target_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_q     <= 1'b0;
            branch_q    <= 1'b0;
            enable_q    <= 1'b0;
            write_q     <= 1'b0;
            reg_write_q <= 1'b0;
            result_q    <= '0;
            wdata_q     <= '0;
            target_q    <= '0;
            sel_q       <= '0;
            reg_addr_q  <= '0;
        end else if (accept) begin
            valid_q     <= 1'b1;
            branch_q    <= branch_taken;
            enable_q    <= ls_enable_i;
            write_q     <= ls_enable_i && ls_write_i;
            reg_write_q <= reg_write_i;
            result_q    <= result_d;
            wdata_q     <= wdata_d;
            target_q    <= target_d;
            sel_q       <= sel_d;
            reg_addr_q  <= reg_addr_i;
        end else begin
            // Data registers hold; branch only pulses in the first valid cycle.
            if (ls.output_ready) valid_q <= 1'b0;
            branch_q <= 1'b0;
        end
    end

    assign ls.output_valid  = valid_q;
    assign ls.alu_result    = result_q;
    assign ls.enable        = enable_q;
    assign ls.write         = write_q;
    assign ls.write_data    = wdata_q;
    assign ls.sel           = sel_q;
    assign ls.reg_write     = reg_write_q;
    assign ls.reg_addr      = reg_addr_q;
    assign ls.branch        = branch_q;
    assign ls.branch_target = target_q;
endmodule
